alu32_exec_stage: RTL and testbench
===================================

// Module: alu32_exec_stage
// PURPOSE
//  Execute stage consuming ALU_Control from the ALU controller plus ID/EX operands.
//  Computes ALU/address/branch results into a registered output. Runs MUL on an iterative
//  shift-add engine, holding the pipeline through In_Ready. Output feeds EX/MEM.
// PARAMETERS
//  DATA_W    32  operand/result width
//  MUL_STEPS 32  MUL iterations, one bit per cycle; must equal DATA_W
// PORTS
//  Clk           in   1   single clock, rising edge
//  Rst_n         in   1   asynchronous, active-low reset
//  In_Valid      in   1   operands/ALU_Control valid this cycle
//  In_Ready      out  1   stage can accept; transfer = In_Valid & In_Ready at edge
//  ALU_Control   in   5   operation code from ALU controller
//  A             in   32  rs operand
//  B             in   32  rt or sign-extended immediate (already muxed)
//  Shamt         in   5   shift amount for SLL/SRL
//  Rt0           in   1   rt[0] for code 19: 1=BGEZ, 0=BLTZ
//  Out_Valid     out  1   ALU_Result/Branch_Taken valid
//  Out_Ready     in   1   downstream accepts; transfer = Out_Valid & Out_Ready at edge
//  ALU_Result    out  32  result / effective address / jump target
//  Branch_Taken  out  1   branch condition true (branch codes only; else 0)
//  Illegal       out  1   captured code not in the table below
// BEHAVIOUR
//  Reset, asynchronous on Rst_n low:
//   - State=IDLE, Out_Valid=0, ALU_Result=0, Branch_Taken=0, Illegal=0, iteration count=0.
//   - A MUL in flight is discarded.
//  Op table, 32-bit wrap arithmetic, no overflow traps:
//   - 0 ADD/ADDI: A+B. 1 SUB: A-B. 2 MUL: low 32 bits of A*B.
//   - 4 AND: A&B. 5 ANDI: A&{16'b0,B[15:0]}. 7 OR: A|B. 8 NOR: ~(A|B). 9 XOR: A^B.
//   - 10 ORI / 11 XORI: same as OR/XOR, but B zero-extended from B[15:0].
//   - 12 SLL: B<<Shamt. 13 SRL: B>>Shamt, logical.
//   - 15 SLT / 16 SLTI: signed A<B ? 1:0.
//   - Branches, ALU_Result=0:
//     17 BEQ A==B; 18 BNE A!=B; 19 Rt0 ? A>=0 : A<0, signed;
//     20 BGTZ A>0; 21 BLEZ A<=0.
//   - 25..30 LW/SW/LB/LH/SB/SH: A+B, the address. 31 JR: A.
//   - Any other code: ALU_Result=0, Branch_Taken=0, Illegal=1.
//  FSM, states IDLE, MUL, HOLD:
//   - IDLE: In_Ready = !Out_Valid | Out_Ready.
//     Accept, non-MUL: result registered; Out_Valid=1 next edge (latency 1); stay IDLE.
//     Accept, MUL: latch A,B; clear acc; count=0; ->MUL.
//   - MUL: In_Ready=0. Each edge: if mcand bit set, acc+=mplier; shift mplier left;
//     shift mcand right; count++. On the MUL_STEPS-th edge, load acc into ALU_Result,
//     set Out_Valid=1, ->IDLE. MUL latency = MUL_STEPS cycles (32) from accept.
//   - HOLD, entered when Out_Valid & !Out_Ready at MUL completion: MUL needs no HOLD,
//     since a MUL is only accepted when the output slot frees. HOLD is reserved.
//     Implementations may omit it and must never enter it.
//  Output register:
//   - Out_Valid drops after Out_Ready transfer unless a new op is accepted that same edge.
//   - Outputs stable while Out_Valid & !Out_Ready.
//  Simultaneous output drain + input accept in one cycle: both occur; no bubble.
//  In_Valid low or In_Ready low: inputs ignored, no state change.
// STRUCTURE
//  Package alu_ctrl_pkg:
//   - localparams for all ALU_Control codes, shared with the ALU controller.
//   - FSM state enum.
//  Sub-module alu_mul_iter, shift-add core:
//   - ports: start, a, b, busy, done (1-cycle), product[31:0].
//   - The top holds the handshake FSM and the combinational op mux.
// TESTING
//  1. ADD A=5,B=7 -> next cycle ALU_Result=12, Out_Valid=1. SUB 5-7 -> 0xFFFFFFFE.
//  2. MUL A=0xFFFFFFFF,B=3 -> In_Ready=0 for 32 cycles, then ALU_Result=0xFFFFFFFD.
//     MUL A=0x10000,B=0x10000 -> 0.
//  3. Branches:
//     BEQ A=B=9 -> Taken=1; BNE A=B=9 -> 0.
//     code19 A=0: Rt0=1 -> Taken=1, Rt0=0 -> Taken=0.
//     BLEZ A=0x80000000 -> Taken=1.
//  4. ORI A=0,B=0xFFFF8000 -> 0x00008000. SLTI A=-1,B=1 -> 1.
//     SRL B=0x80000000,Shamt=31 -> 1. Code 3 -> Illegal=1, result 0.
//  5. Out_Ready=0 for 4 cycles after ADD -> outputs held, In_Ready=0.
//     Release with new op on same edge -> back-to-back Out_Valid.
//  6. Rst_n low at MUL cycle 10 -> Out_Valid=0 immediately.
//     After release, ADD 1+1 -> 2 in 1 cycle.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU_Control encodings, widths and execute-stage FSM states.
// The ALU controller and the execute stage both import this package.
package alu_ctrl_pkg;

   localparam int DATA_W    = 32;
   localparam int MUL_STEPS = 32;
   localparam int CNT_W     = 6;

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_MUL   = 5'd2;
   localparam logic [4:0] OP_AND   = 5'd4;
   localparam logic [4:0] OP_ANDI  = 5'd5;
   localparam logic [4:0] OP_OR    = 5'd7;
   localparam logic [4:0] OP_NOR   = 5'd8;
   localparam logic [4:0] OP_XOR   = 5'd9;
   localparam logic [4:0] OP_ORI   = 5'd10;
   localparam logic [4:0] OP_XORI  = 5'd11;
   localparam logic [4:0] OP_SLL   = 5'd12;
   localparam logic [4:0] OP_SRL   = 5'd13;
   localparam logic [4:0] OP_SLT   = 5'd15;
   localparam logic [4:0] OP_SLTI  = 5'd16;
   localparam logic [4:0] OP_BEQ   = 5'd17;
   localparam logic [4:0] OP_BNE   = 5'd18;
   localparam logic [4:0] OP_BCOND = 5'd19;
   localparam logic [4:0] OP_BGTZ  = 5'd20;
   localparam logic [4:0] OP_BLEZ  = 5'd21;
   localparam logic [4:0] OP_LW    = 5'd25;
   localparam logic [4:0] OP_SW    = 5'd26;
   localparam logic [4:0] OP_LB    = 5'd27;
   localparam logic [4:0] OP_LH    = 5'd28;
   localparam logic [4:0] OP_SB    = 5'd29;
   localparam logic [4:0] OP_SH    = 5'd30;
   localparam logic [4:0] OP_JR    = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } exec_state_e;

endpackage

// File: rtl/alu32_exec_stage_if.sv
// ID/EX to EX/MEM handshake bundle of the execute stage.
// The master side drives operands and Out_Ready; the slave side is the stage.
interface alu32_exec_if;
   import alu_ctrl_pkg::*;

   logic              In_Valid;
   logic              In_Ready;
   logic [4:0]        ALU_Control;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [4:0]        Shamt;
   logic              Rt0;
   logic              Out_Valid;
   logic              Out_Ready;
   logic [DATA_W-1:0] ALU_Result;
   logic              Branch_Taken;
   logic              Illegal;

   modport master (
      output In_Valid, ALU_Control, A, B, Shamt, Rt0, Out_Ready,
      input  In_Ready, Out_Valid, ALU_Result, Branch_Taken, Illegal
   );

   modport slave (
      input  In_Valid, ALU_Control, A, B, Shamt, Rt0, Out_Ready,
      output In_Ready, Out_Valid, ALU_Result, Branch_Taken, Illegal
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplicand bit per cycle.
// product presents the final sum combinationally in the cycle done is high.
module alu_mul_iter
   import alu_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   logic [DATA_W-1:0] mcand_r;
   logic [DATA_W-1:0] mplier_r;
   logic [DATA_W-1:0] acc_r;
   logic [CNT_W-1:0]  count_r;
   logic              busy_r;
   logic [DATA_W-1:0] step_add_s;

   // Partial-sum adder and completion flag for the current iteration.
   always_comb begin
      step_add_s = mcand_r[0] ? mplier_r : {DATA_W{1'b0}};
      product    = acc_r + step_add_s;
      done       = busy_r && (count_r == CNT_W'(MUL_STEPS - 1));
      busy       = busy_r;
   end

   // Operand load on start, then one shift-add step per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r  <= {DATA_W{1'b0}};
         mplier_r <= {DATA_W{1'b0}};
         acc_r    <= {DATA_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         busy_r   <= 1'b0;
      end else if (start) begin
         mcand_r  <= b;
         mplier_r <= a;
         acc_r    <= {DATA_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         busy_r   <= 1'b1;
      end else if (busy_r) begin
         acc_r    <= product;
         mplier_r <= mplier_r << 1;
         mcand_r  <= mcand_r >> 1;
         count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         busy_r   <= !done;
      end else begin
         busy_r   <= 1'b0;
      end
   end

endmodule

// File: rtl/alu32_exec_stage.sv
// Execute stage: single-cycle ALU/branch/address ops and an iterative MUL,
// with a one-entry registered output slot toward EX/MEM.
module alu32_exec_stage
   import alu_ctrl_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst_n,
   alu32_exec_if.slave bus
);

   exec_state_e       state_r;
   exec_state_e       state_next_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              mul_start_s;
   logic              mul_busy_s;
   logic              mul_done_s;
   logic              mul_finish_s;
   logic [DATA_W-1:0] mul_product_s;
   logic [DATA_W-1:0] op_result_s;
   logic              op_taken_s;
   logic              op_illegal_s;
   logic              out_valid_r;
   logic [DATA_W-1:0] result_r;
   logic              taken_r;
   logic              illegal_r;

   alu_mul_iter u_mul (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .start   (mul_start_s),
      .a       (bus.A),
      .b       (bus.B),
      .busy    (mul_busy_s),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Handshake decode and next-state logic.
   always_comb begin
      state_next_s = state_r;
      in_ready_s   = (state_r == ST_IDLE) && !mul_busy_s && (!out_valid_r || bus.Out_Ready);
      accept_s     = bus.In_Valid && in_ready_s;
      mul_start_s  = accept_s && (bus.ALU_Control == OP_MUL);
      mul_finish_s = (state_r == ST_MUL) && mul_done_s;
      case (state_r)
         ST_IDLE: state_next_s = mul_start_s ? ST_MUL : ST_IDLE;
         ST_MUL:  state_next_s = mul_done_s ? ST_IDLE : ST_MUL;
         ST_HOLD: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Single-cycle operation mux; MUL results come from the iterative core.
   always_comb begin
      op_result_s  = {DATA_W{1'b0}};
      op_taken_s   = 1'b0;
      op_illegal_s = 1'b0;
      case (bus.ALU_Control)
         OP_ADD:   op_result_s = bus.A + bus.B;
         OP_SUB:   op_result_s = bus.A - bus.B;
         OP_MUL:   op_result_s = {DATA_W{1'b0}};
         OP_AND:   op_result_s = bus.A & bus.B;
         OP_ANDI:  op_result_s = bus.A & {16'd0, bus.B[15:0]};
         OP_OR:    op_result_s = bus.A | bus.B;
         OP_NOR:   op_result_s = ~(bus.A | bus.B);
         OP_XOR:   op_result_s = bus.A ^ bus.B;
         OP_ORI:   op_result_s = bus.A | {16'd0, bus.B[15:0]};
         OP_XORI:  op_result_s = bus.A ^ {16'd0, bus.B[15:0]};
         OP_SLL:   op_result_s = bus.B << bus.Shamt;
         OP_SRL:   op_result_s = bus.B >> bus.Shamt;
         OP_SLT,
         OP_SLTI:  op_result_s = {31'd0, ($signed(bus.A) < $signed(bus.B))};
         OP_BEQ:   op_taken_s  = (bus.A == bus.B);
         OP_BNE:   op_taken_s  = (bus.A != bus.B);
         OP_BCOND: op_taken_s  = bus.Rt0 ? !bus.A[31] : bus.A[31];
         OP_BGTZ:  op_taken_s  = !bus.A[31] && (bus.A != 32'd0);
         OP_BLEZ:  op_taken_s  = bus.A[31] || (bus.A == 32'd0);
         OP_LW, OP_SW, OP_LB,
         OP_LH, OP_SB, OP_SH:
                   op_result_s = bus.A + bus.B;
         OP_JR:    op_result_s = bus.A;
         default:  op_illegal_s = 1'b1;
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Output slot: load on accept or MUL completion, release on downstream transfer.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         out_valid_r <= 1'b0;
         result_r    <= {DATA_W{1'b0}};
         taken_r     <= 1'b0;
         illegal_r   <= 1'b0;
      end else if (accept_s && !mul_start_s) begin
         out_valid_r <= 1'b1;
         result_r    <= op_result_s;
         taken_r     <= op_taken_s;
         illegal_r   <= op_illegal_s;
      end else if (mul_finish_s) begin
         out_valid_r <= 1'b1;
         result_r    <= mul_product_s;
         taken_r     <= 1'b0;
         illegal_r   <= 1'b0;
      end else if (out_valid_r && bus.Out_Ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign bus.In_Ready     = in_ready_s;
   assign bus.Out_Valid    = out_valid_r;
   assign bus.ALU_Result   = result_r;
   assign bus.Branch_Taken = taken_r;
   assign bus.Illegal      = illegal_r;

endmodule

// File: tb/tb_alu32_exec_stage.sv
// Self-checking bench for alu32_exec_stage: vector table through a scoreboard
// plus hand-written MUL, back-pressure and mid-MUL reset sequences.
module tb_alu32_exec_stage;
   import alu_ctrl_pkg::*;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   alu32_exec_if bus();

   alu32_exec_stage dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic        rt0;
      logic [31:0] res;
      logic        tk;
      logic        ill;
   } vec_t;

   vec_t        vecs[$];
   logic [33:0] sb_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic rt0, input logic [31:0] res,
                          input logic tk, input logic ill);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.sh = sh; v.rt0 = rt0;
      v.res = res; v.tk = tk; v.ill = ill;
      vecs.push_back(v);
   endtask

   // Scoreboard compare of the output transferring at the coming edge, then advance one cycle.
   task automatic tick();
      logic [33:0] exp_v;
      if (bus.Out_Valid && bus.Out_Ready) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_unexpected: got output %h, expected none",
                     {bus.ALU_Result, bus.Branch_Taken, bus.Illegal});
         end else begin
            exp_v = sb_q.pop_front();
            chk("sb_out", {30'd0, bus.ALU_Result, bus.Branch_Taken, bus.Illegal}, {30'd0, exp_v});
         end
      end
      @(negedge Clk);
   endtask

   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic rt0, input logic [33:0] exp_v);
      int w;
      bus.ALU_Control = op; bus.A = a; bus.B = b; bus.Shamt = sh; bus.Rt0 = rt0;
      bus.In_Valid = 1'b1;
      #1;
      w = 0;
      while (!bus.In_Ready && w < 200) begin
         tick();
         #1;
         w++;
      end
      if (!bus.In_Ready) begin
         n_chk++;
         $display("FAIL in_ready_timeout: got In_Ready=0 after %0d cycles, expected 1", w);
      end else begin
         sb_q.push_back(exp_v);
         tick();
      end
      bus.In_Valid = 1'b0;
   endtask

   task automatic mul_check(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] p;
      int cnt;
      p = a * b;
      send(OP_MUL, a, b, 5'd0, 1'b0, {p, 1'b0, 1'b0});
      cnt = 0;
      while (!bus.In_Ready && cnt < 100) begin
         cnt++;
         tick();
      end
      chk("mul_ready_low_cycles", 64'(cnt), 64'd32);
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() > 0 && w < 100) begin
         tick();
         w++;
      end
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      bus.In_Valid = 1'b0; bus.ALU_Control = 5'd0; bus.A = 32'd0; bus.B = 32'd0;
      bus.Shamt = 5'd0; bus.Rt0 = 1'b0; bus.Out_Ready = 1'b1;

      add_vec(OP_ADD,   32'd5,        32'd7,        5'd0,  1'b0, 32'd12,       1'b0, 1'b0);
      add_vec(OP_SUB,   32'd5,        32'd7,        5'd0,  1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
      add_vec(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'hF000F000, 1'b0, 1'b0);
      add_vec(OP_ANDI,  32'hFFFFFFFF, 32'hFFFF1234, 5'd0,  1'b0, 32'h00001234, 1'b0, 1'b0);
      add_vec(OP_OR,    32'h12340000, 32'h00005678, 5'd0,  1'b0, 32'h12345678, 1'b0, 1'b0);
      add_vec(OP_NOR,   32'd0,        32'd0,        5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
      add_vec(OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  1'b0, 32'hF0F00F0F, 1'b0, 1'b0);
      add_vec(OP_ORI,   32'd0,        32'hFFFF8000, 5'd0,  1'b0, 32'h00008000, 1'b0, 1'b0);
      add_vec(OP_XORI,  32'hFFFFFFFF, 32'hFFFF00FF, 5'd0,  1'b0, 32'hFFFFFF00, 1'b0, 1'b0);
      add_vec(OP_SLL,   32'h0000FFFF, 32'd1,        5'd31, 1'b0, 32'h80000000, 1'b0, 1'b0);
      add_vec(OP_SRL,   32'd0,        32'h80000000, 5'd31, 1'b0, 32'd1,        1'b0, 1'b0);
      add_vec(OP_SLT,   32'hFFFFFFFB, 32'd3,        5'd0,  1'b0, 32'd1,        1'b0, 1'b0);
      add_vec(OP_SLT,   32'd3,        32'hFFFFFFFB, 5'd0,  1'b0, 32'd0,        1'b0, 1'b0);
      add_vec(OP_SLTI,  32'hFFFFFFFF, 32'd1,        5'd0,  1'b0, 32'd1,        1'b0, 1'b0);
      add_vec(OP_BEQ,   32'd9,        32'd9,        5'd0,  1'b0, 32'd0,        1'b1, 1'b0);
      add_vec(OP_BNE,   32'd9,        32'd9,        5'd0,  1'b0, 32'd0,        1'b0, 1'b0);
      add_vec(OP_BCOND, 32'd0,        32'd0,        5'd0,  1'b1, 32'd0,        1'b1, 1'b0);
      add_vec(OP_BCOND, 32'd0,        32'd0,        5'd0,  1'b0, 32'd0,        1'b0, 1'b0);
      add_vec(OP_BCOND, 32'hFFFFFFFF, 32'd0,        5'd0,  1'b0, 32'd0,        1'b1, 1'b0);
      add_vec(OP_BGTZ,  32'd1,        32'd0,        5'd0,  1'b0, 32'd0,        1'b1, 1'b0);
      add_vec(OP_BGTZ,  32'd0,        32'd0,        5'd0,  1'b0, 32'd0,        1'b0, 1'b0);
      add_vec(OP_BLEZ,  32'h80000000, 32'd0,        5'd0,  1'b0, 32'd0,        1'b1, 1'b0);
      add_vec(OP_BLEZ,  32'd1,        32'd0,        5'd0,  1'b0, 32'd0,        1'b0, 1'b0);
      add_vec(OP_LW,    32'h00001000, 32'hFFFFFFFC, 5'd0,  1'b0, 32'h00000FFC, 1'b0, 1'b0);
      add_vec(OP_SH,    32'hFFFFFFFF, 32'd2,        5'd0,  1'b0, 32'd1,        1'b0, 1'b0);
      add_vec(OP_JR,    32'h00400020, 32'h00000123, 5'd0,  1'b0, 32'h00400020, 1'b0, 1'b0);
      add_vec(5'd3,     32'd5,        32'd7,        5'd0,  1'b0, 32'd0,        1'b0, 1'b1);
      add_vec(5'd6,     32'd5,        32'd7,        5'd0,  1'b0, 32'd0,        1'b0, 1'b1);
      add_vec(5'd22,    32'd5,        32'd7,        5'd0,  1'b0, 32'd0,        1'b0, 1'b1);

      repeat (3) @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("rst_out_valid", 64'(bus.Out_Valid), 64'd0);
      chk("rst_result", 64'(bus.ALU_Result), 64'd0);
      chk("rst_taken", 64'(bus.Branch_Taken), 64'd0);
      chk("rst_illegal", 64'(bus.Illegal), 64'd0);
      chk("rst_in_ready", 64'(bus.In_Ready), 64'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].rt0,
              {vecs[i].res, vecs[i].tk, vecs[i].ill});
      end
      drain();

      mul_check(32'hFFFFFFFF, 32'd3);
      mul_check(32'h00010000, 32'h00010000);
      for (int i = 0; i < 2; i++) begin
         mul_check($urandom, $urandom);
      end
      drain();

      // Back-pressure: result must hold, then release with a new op on the same edge.
      bus.Out_Ready = 1'b0;
      send(OP_ADD, 32'd100, 32'd23, 5'd0, 1'b0, {32'd123, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", 64'(bus.Out_Valid), 64'd1);
         chk("stall_result", 64'(bus.ALU_Result), 64'd123);
         chk("stall_in_ready", 64'(bus.In_Ready), 64'd0);
         tick();
      end
      bus.Out_Ready = 1'b1;
      send(OP_SUB, 32'd10, 32'd3, 5'd0, 1'b0, {32'd7, 1'b0, 1'b0});
      chk("b2b_valid", 64'(bus.Out_Valid), 64'd1);
      chk("b2b_result", 64'(bus.ALU_Result), 64'd7);
      drain();

      // Reset in the middle of a MUL discards it and clears the output slot.
      send(OP_MUL, 32'd7, 32'd9, 5'd0, 1'b0, {32'd63, 1'b0, 1'b0});
      repeat (9) tick();
      Rst_n = 1'b0;
      #1;
      chk("midmul_rst_valid", 64'(bus.Out_Valid), 64'd0);
      chk("midmul_rst_result", 64'(bus.ALU_Result), 64'd0);
      sb_q.delete();
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (40) tick();
      chk("post_rst_no_output", 64'(bus.Out_Valid), 64'd0);
      chk("post_rst_in_ready", 64'(bus.In_Ready), 64'd1);
      send(OP_ADD, 32'd1, 32'd1, 5'd0, 1'b0, {32'd2, 1'b0, 1'b0});
      chk("post_rst_add_valid", 64'(bus.Out_Valid), 64'd1);
      chk("post_rst_add_result", 64'(bus.ALU_Result), 64'd2);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
